// File: rtl/wt_l15_req_queue_if.sv
// Request/issue/return bundle between the dcache, the L1.5 request queue and
// the L1.5. The queue uses the slave modport; the dcache/L1.5 side uses master.
interface wt_l15_req_queue_if #(
    parameter int TID_W   = 2,
    parameter int ADDR_W  = 40,
    parameter int MAX_OUT = 4
);
    localparam int OUT_W = $clog2(MAX_OUT + 1);

    logic              req_valid_i;
    logic              req_ready_o;
    logic              req_we_i;
    logic [ADDR_W-1:0] req_addr_i;
    logic [1:0]        req_size_i;
    logic [63:0]       req_wdata_i;
    logic [TID_W-1:0]  req_tid_i;

    logic              l15_val_o;
    logic              l15_req_ack_i;
    logic              l15_rqtype_o;
    logic [ADDR_W-1:0] l15_address_o;
    logic [1:0]        l15_size_o;
    logic [63:0]       l15_data_o;
    logic [TID_W-1:0]  l15_threadid_o;

    logic              rtn_val_i;
    logic [OUT_W-1:0]  outstanding_o;
    logic              empty_o;

    modport slave (
        input  req_valid_i, req_we_i, req_addr_i, req_size_i, req_wdata_i, req_tid_i,
        input  l15_req_ack_i, rtn_val_i,
        output req_ready_o, l15_val_o, l15_rqtype_o, l15_address_o, l15_size_o,
        output l15_data_o, l15_threadid_o, outstanding_o, empty_o
    );

    modport master (
        output req_valid_i, req_we_i, req_addr_i, req_size_i, req_wdata_i, req_tid_i,
        output l15_req_ack_i, rtn_val_i,
        input  req_ready_o, l15_val_o, l15_rqtype_o, l15_address_o, l15_size_o,
        input  l15_data_o, l15_threadid_o, outstanding_o, empty_o
    );
endinterface

// File: rtl/wt_l15_req_queue.sv
// Write-through dcache -> L1.5 request queue: in-order FIFO, two-state issue
// FSM with a registered head copy, and an outstanding-credit counter.
// Optional macro WT_L15_BYTE_SWAP_EN: byte-reverse the formatted store data
// for a big-endian L1.5; default build leaves it little-endian.
module wt_l15_req_queue #(
    parameter int DEPTH   = 4,
    parameter int TID_W   = 2,
    parameter int MAX_OUT = 4,
    parameter int ADDR_W  = 40
) (
    input logic              clk_i,
    input logic              rst_i,
    wt_l15_req_queue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int OUT_W = $clog2(MAX_OUT + 1);
    localparam logic [CNT_W-1:0] DEPTH_V   = CNT_W'(DEPTH);
    localparam logic [OUT_W-1:0] MAX_OUT_V = OUT_W'(MAX_OUT);

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [1:0]        size;
        logic [63:0]       data;
        logic [TID_W-1:0]  tid;
    } req_t;

    typedef enum logic {IDLE, SEND} state_t;

    req_t             mem [DEPTH];
    logic [PTR_W-1:0] wptr, rptr;
    logic [CNT_W-1:0] cnt;
    logic [OUT_W-1:0] out_q;
    state_t           state, state_nxt;
    req_t             head_q, head_nxt;
    logic             push, pop, ack, rtn_dec;

    // Replicate the access into all lanes; loads carry no data.
    function automatic logic [63:0] fmt_data(logic we, logic [1:0] size, logic [63:0] d);
        logic [63:0] rep;
        logic [63:0] swp;
        rep = d;
        swp = '0;
        if (!we) return 64'd0;
        case (size)
            2'd0:    rep = {8{d[7:0]}};
            2'd1:    rep = {4{d[15:0]}};
            2'd2:    rep = {2{d[31:0]}};
            default: rep = d;
        endcase
`ifdef WT_L15_BYTE_SWAP_EN
        for (int i = 0; i < 8; i++) swp[8*i +: 8] = rep[8*(7-i) +: 8];
        return swp;
`else
        return rep;
`endif
    endfunction

    assign push    = bus.req_valid_i && bus.req_ready_o;
    // Ready depends only on occupancy, never on a same-cycle pop.
    assign bus.req_ready_o = (cnt < DEPTH_V);
    assign rtn_dec = bus.rtn_val_i && (out_q != '0);

    // FIFO storage; contents need no reset since cnt gates every read.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wptr] <= '{we: bus.req_we_i, addr: bus.req_addr_i, size: bus.req_size_i,
                           data: bus.req_wdata_i, tid: bus.req_tid_i};
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push) wptr <= wptr + PTR_W'(1);
            if (pop)  rptr <= rptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Issue FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    // Issue FSM: leave IDLE only with a queued request and a free credit;
    // ack is only meaningful while a request is presented.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        ack       = 1'b0;
        case (state)
            IDLE: if (cnt != '0 && out_q < MAX_OUT_V) begin
                state_nxt = SEND;
                pop       = 1'b1;
            end
            SEND: if (bus.l15_req_ack_i) begin
                state_nxt = IDLE;
                ack       = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Formatted copy of the FIFO head, captured when it is popped.
    always_comb begin
        head_nxt      = mem[rptr];
        head_nxt.data = fmt_data(mem[rptr].we, mem[rptr].size, mem[rptr].data);
    end

    // Registered head keeps the L1.5 fields stable for the whole SEND phase.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)    head_q <= '0;
        else if (pop) head_q <= head_nxt;
    end

    // Outstanding credits: ack adds one, a return removes one, saturating at 0.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_q <= '0;
        end else begin
            case ({ack, rtn_dec})
                2'b10:   out_q <= out_q + OUT_W'(1);
                2'b01:   out_q <= out_q - OUT_W'(1);
                default: out_q <= out_q;
            endcase
        end
    end

    assign bus.l15_val_o      = (state == SEND);
    assign bus.l15_rqtype_o   = head_q.we;
    assign bus.l15_address_o  = head_q.addr;
    assign bus.l15_size_o     = head_q.size;
    assign bus.l15_data_o     = head_q.data;
    assign bus.l15_threadid_o = head_q.tid;
    assign bus.outstanding_o  = out_q;
    assign bus.empty_o        = (cnt == '0) && (out_q == '0);
endmodule
